riscv_wb_ctrl: RTL and testbench
================================

# riscv_wb_ctrl

Writeback sequencer for the RISC-V core's single register-file write port. Sits between the final pipeline stage and the writeback mux. Drives the mux select and register-file write strobe/address, and stalls the pipeline while a load waits on a variable-latency data memory. Exports the pending destination register for hazard detection.

## Interface
Parameters:
- `WORD_LENGTH`, 32, datapath width; kept for codebase uniformity, no datapath passes through this block.
- `MEM_TIMEOUT`, 255, maximum WAIT_MEM cycles before abort; used only with `RISCV_WB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous active-low reset.
- `wb_valid` in 1: writeback request from the pipeline.
- `wb_ready` out 1: request accepted this cycle.
- `wb_rd` in 5: destination register.
- `wb_rf_we` in 1: instruction writes rd.
- `wb_sel_in` in WB_SEL: requested source.
- `mem_rvalid` in 1: load data valid at the mux `data` input this cycle.
- `wb_sel` out WB_SEL: select to the writeback mux.
- `rf_we` out 1: register-file write enable.
- `rf_waddr` out 5: register-file write address.
- `pend_valid` out 1: a load is outstanding.
- `pend_rd` out 5: destination register of the outstanding load.
- `retire` out 1: one-cycle pulse per completed writeback request.
- `timeout_err` out 1: one-cycle pulse on load abort; tied 0 without the macro.

## Operation
- FSM states: IDLE, WAIT_MEM.
- **IDLE:** `wb_ready`=1.
  - If `wb_valid` with `wb_sel_in`≠WB_MEM: `wb_sel`=`wb_sel_in`, `rf_waddr`=`wb_rd`, `rf_we`=`wb_rf_we` && `wb_rd`≠0, `retire`=1. Stay in IDLE.
  - If `wb_valid` with WB_MEM and `mem_rvalid` high: complete in the same cycle as above, with `wb_sel`=WB_MEM (zero-wait load). Stay in IDLE.
  - If `wb_valid` with WB_MEM and `mem_rvalid` low: latch `wb_rd`/`wb_rf_we`, `rf_we`=0, `retire`=0, go to WAIT_MEM.
  - With no request: `wb_sel`=WB_ALU, `rf_we`=0, `rf_waddr`=0.
  - `mem_rvalid` without a WB_MEM request is ignored.
- **WAIT_MEM:**
  - Held every cycle: `wb_ready`=0, `wb_sel`=WB_MEM, `rf_waddr`=latched rd, `pend_valid`=1, `pend_rd`=latched rd.
  - On `mem_rvalid`: `rf_we`=latched we && rd≠0, `retire`=1, go to IDLE.
- A new request is never accepted in WAIT_MEM, so at most one write occurs per cycle.
- `pend_valid`=0 and `pend_rd`=0 in IDLE.
- Writes to x0 are never strobed, but they still retire.

## Timing
- Non-memory and zero-wait load writeback: 0-cycle latency, combinational from request to `rf_we`.
- Waited load: accepted on cycle N, write on the cycle `mem_rvalid` rises (N+k, k≥1), IDLE on N+k+1. The next request is accepted on N+k+1 at the earliest, giving one bubble.
- While `rst_n`=0:
  - State is IDLE.
  - Outputs: `wb_ready`=0, `rf_we`=0, `wb_sel`=WB_ALU, `rf_waddr`=0, `pend_valid`=0, `pend_rd`=0, `retire`=0, `timeout_err`=0.
  - Reset in WAIT_MEM drops the pending write; no `retire` is generated.
- Outputs are combinational from state, latched registers and inputs. All registers are updated on the `clk` rising edge.

## Configuration
- Macro: `RISCV_WB_TIMEOUT_EN`.
- **Defined:**
  - A wait counter clears on WAIT_MEM entry and increments each WAIT_MEM cycle without `mem_rvalid`.
  - When the count reaches `MEM_TIMEOUT` with `mem_rvalid` still low: `timeout_err`=1, `rf_we`=0, `retire`=0, go to IDLE.
  - `mem_rvalid` on the same cycle as the limit wins: normal completion, no error.
  - Counter width is $clog2(MEM_TIMEOUT+1).
  - A late `mem_rvalid` after abort is ignored in IDLE.
- **Undefined:** no counter; WAIT_MEM waits indefinitely; `timeout_err` is constant 0.

## Structure
- WB_SEL (WB_ALU, WB_MEM, WB_PC, WB_CSR) stays in the shared package `riscv_constants.sv`.
- Add the WB_CTRL_STATE enum (IDLE, WAIT_MEM) to the same package.
- One sub-module: `riscv_wb_timeout`, the parameterised saturating wait counter. Instantiate it only under `RISCV_WB_TIMEOUT_EN`.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles, release → all outputs at reset values while low; `wb_ready`=1 on the first cycle after release.
- **ALU write:** `wb_valid`, WB_ALU, rd=5, we=1 → same cycle `rf_we`=1, `rf_waddr`=5, `wb_sel`=WB_ALU, `retire`=1. Repeat with rd=0 → `rf_we`=0, `retire`=1.
- **Zero-wait load:** WB_MEM, rd=7, `mem_rvalid`=1 in the same cycle → write to 7 that cycle; a back-to-back WB_CSR rd=3 is accepted next cycle with no bubble.
- **Waited load:** WB_MEM, rd=9, `mem_rvalid` 4 cycles later → `pend_valid`=1, `pend_rd`=9, `wb_ready`=0 for those cycles; `rf_we`=1 with addr 9 on the rvalid cycle; `wb_ready`=1 the following cycle. Spurious `mem_rvalid` in IDLE → no write.
- **Timeout (macro on, `MEM_TIMEOUT`=4):** load with no rvalid → `timeout_err` pulses once at the limit, no write, IDLE next cycle. Rvalid exactly at the limit → normal write, no error.
- **Reset mid-load:** assert `rst_n`=0 two cycles into WAIT_MEM, then rvalid → no `rf_we`, `pend_valid`=0, `retire` never pulses.

Source files
------------

// File: rtl/riscv_constants.sv
// rtl/riscv_constants.sv - shared RISC-V core constants: writeback source select and writeback sequencer states
package riscv_constants;

  // Source selected by the writeback mux.
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2,
    WB_CSR = 2'd3
  } wb_sel_e;

  // Writeback sequencer states.
  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_ctrl_state_e;

  localparam int unsigned RF_ADDR_W = 5;

endpackage

// File: rtl/riscv_wb_timeout.sv
// rtl/riscv_wb_timeout.sv - saturating wait-cycle counter for outstanding loads
module riscv_wb_timeout #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear on entry to the wait, count idle wait cycles, hold once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_W'(MEM_TIMEOUT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/riscv_wb_ctrl.sv
// rtl/riscv_wb_ctrl.sv - writeback sequencer for the single register-file write port (optional load abort: RISCV_WB_TIMEOUT_EN)
module riscv_wb_ctrl
  import riscv_constants::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [RF_ADDR_W-1:0] wb_rd,
  input  logic                 wb_rf_we,
  input  wb_sel_e              wb_sel_in,
  input  logic                 mem_rvalid,
  output wb_sel_e              wb_sel,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic                 pend_valid,
  output logic [RF_ADDR_W-1:0] pend_rd,
  output logic                 retire,
  output logic                 timeout_err
);

  // Reject nonsensical parameterisations at elaboration.
  if ((WORD_LENGTH < 1) || (MEM_TIMEOUT < 1)) begin : g_bad_param
    $error("riscv_wb_ctrl: WORD_LENGTH and MEM_TIMEOUT must be positive");
  end

  wb_ctrl_state_e       state_q, state_d;
  logic [RF_ADDR_W-1:0] rd_q, rd_d;
  logic                 we_q, we_d;

`ifdef RISCV_WB_TIMEOUT_EN
  logic wait_clr;
  logic wait_inc;
  logic wait_limit;

  // The counter restarts on the cycle a waited load is accepted and ticks on every empty wait cycle.
  assign wait_clr = (state_q == IDLE) && wb_valid && (wb_sel_in == WB_MEM) && !mem_rvalid;
  assign wait_inc = (state_q == WAIT_MEM) && !mem_rvalid;

  riscv_wb_timeout #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (wait_clr),
    .inc      (wait_inc),
    .at_limit (wait_limit)
  );
`endif

  // Next state and port outputs; everything is forced to its reset value while rst_n is low.
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    we_d        = we_q;
    wb_ready    = 1'b0;
    wb_sel      = WB_ALU;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    pend_valid  = 1'b0;
    pend_rd     = '0;
    retire      = 1'b0;
    timeout_err = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          wb_ready = 1'b1;
          if (wb_valid) begin
            if ((wb_sel_in != WB_MEM) || mem_rvalid) begin
              // Non-load or zero-wait load: write straight through this cycle.
              wb_sel   = wb_sel_in;
              rf_waddr = wb_rd;
              rf_we    = wb_rf_we && (wb_rd != '0);
              retire   = 1'b1;
            end else begin
              // Load data not yet back: remember the destination and stall.
              wb_sel   = WB_MEM;
              rf_waddr = wb_rd;
              rd_d     = wb_rd;
              we_d     = wb_rf_we;
              state_d  = WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          wb_sel     = WB_MEM;
          rf_waddr   = rd_q;
          pend_valid = 1'b1;
          pend_rd    = rd_q;
          if (mem_rvalid) begin
            rf_we   = we_q && (rd_q != '0);
            retire  = 1'b1;
            state_d = IDLE;
          end
`ifdef RISCV_WB_TIMEOUT_EN
          else if (wait_limit) begin
            // Memory never answered: abandon the write without retiring.
            timeout_err = 1'b1;
            state_d     = IDLE;
          end
`endif
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and pending-load registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
    end
  end

endmodule

// File: tb/tb_riscv_wb_ctrl.sv
// tb/tb_riscv_wb_ctrl.sv - self-checking bench for riscv_wb_ctrl
module tb_riscv_wb_ctrl;
  import riscv_constants::*;

  localparam int MEM_TO = 4;
`ifdef RISCV_WB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       wb_valid;
  logic       wb_ready;
  logic [4:0] wb_rd;
  logic       wb_rf_we;
  wb_sel_e    wb_sel_in;
  logic       mem_rvalid;
  wb_sel_e    wb_sel;
  logic       rf_we;
  logic [4:0] rf_waddr;
  logic       pend_valid;
  logic [4:0] pend_rd;
  logic       retire;
  logic       timeout_err;

  riscv_wb_ctrl #(
    .WORD_LENGTH (32),
    .MEM_TIMEOUT (MEM_TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rd       (wb_rd),
    .wb_rf_we    (wb_rf_we),
    .wb_sel_in   (wb_sel_in),
    .mem_rvalid  (mem_rvalid),
    .wb_sel      (wb_sel),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .pend_valid  (pend_valid),
    .pend_rd     (pend_rd),
    .retire      (retire),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       v;
    logic [4:0] rd;
    logic       we;
    wb_sel_e    sel;
    logic       rv;
  } stim_t;

  typedef struct {
    logic       ready;
    logic       we;
    logic [4:0] waddr;
    wb_sel_e    sel;
    logic       ret;
    logic       pv;
    logic [4:0] prd;
    logic       err;
    logic       chk_mux;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  typedef struct {
    logic [4:0] rd;
    logic       we;
  } pend_t;

  int    checks = 0;
  int    errors = 0;
  vec_t  tbl[$];
  pend_t pend[$];
  int    waited = 0;

  function automatic stim_t S(logic r, logic v, logic [4:0] rd, logic we, wb_sel_e sel, logic rv);
    stim_t s;
    s.rst_n = r; s.v = v; s.rd = rd; s.we = we; s.sel = sel; s.rv = rv;
    return s;
  endfunction

  function automatic exp_t E(logic ready, logic we, logic [4:0] waddr, wb_sel_e sel, logic ret,
                             logic pv, logic [4:0] prd, logic err, logic chk_mux);
    exp_t e;
    e.ready = ready; e.we = we; e.waddr = waddr; e.sel = sel; e.ret = ret;
    e.pv = pv; e.prd = prd; e.err = err; e.chk_mux = chk_mux;
    return e;
  endfunction

  function automatic void add(stim_t s, exp_t e);
    vec_t x;
    x.s = s; x.e = e;
    tbl.push_back(x);
  endfunction

  // Reference: at most one load in flight, tracked as a queue plus a count of empty wait cycles.
  function automatic exp_t model(stim_t s);
    exp_t e = E(0, 0, 0, WB_ALU, 0, 0, 0, 0, 1);
    if (!s.rst_n) begin
      pend.delete();
      waited = 0;
      return e;
    end
    if (pend.size() == 0) begin
      e.ready = 1;
      if (s.v) begin
        if (s.sel != WB_MEM || s.rv) begin
          e.sel = s.sel; e.waddr = s.rd; e.we = s.we && (s.rd != 0); e.ret = 1;
        end else begin
          pend.push_back('{rd: s.rd, we: s.we});
          waited = 0;
          e.chk_mux = 0;
        end
      end
    end else begin
      e.sel = WB_MEM; e.waddr = pend[0].rd; e.pv = 1; e.prd = pend[0].rd;
      if (s.rv) begin
        e.we = pend[0].we && (pend[0].rd != 0);
        e.ret = 1;
        pend.delete();
      end else if (TIMEOUT_ON && waited == MEM_TO) begin
        e.err = 1;
        pend.delete();
      end else begin
        waited++;
      end
    end
    return e;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(stim_t s);
    rst_n      = s.rst_n;
    wb_valid   = s.v;
    wb_rd      = s.rd;
    wb_rf_we   = s.we;
    wb_sel_in  = s.sel;
    mem_rvalid = s.rv;
  endtask

  task automatic compare(int idx, exp_t e);
    chk("wb_ready", idx, 32'(wb_ready), 32'(e.ready));
    chk("rf_we", idx, 32'(rf_we), 32'(e.we));
    chk("retire", idx, 32'(retire), 32'(e.ret));
    chk("pend_valid", idx, 32'(pend_valid), 32'(e.pv));
    chk("pend_rd", idx, 32'(pend_rd), 32'(e.prd));
    chk("timeout_err", idx, 32'(timeout_err), 32'(e.err));
    if (e.chk_mux) begin
      chk("wb_sel", idx, 32'(wb_sel), 32'(e.sel));
      chk("rf_waddr", idx, 32'(rf_waddr), 32'(e.waddr));
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
  task automatic step(stim_t s, exp_t e, int idx);
    drive(s);
    #2;
    compare(idx, e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(S(0, 0, 0, 0, WB_ALU, 0));

    // Reset held three cycles with live request inputs, then release.
    for (int i = 0; i < 3; i++) add(S(0, 1, 5, 1, WB_MEM, 1), E(0, 0, 0, WB_ALU, 0, 0, 0, 0, 1));
    add(S(1, 0, 0, 0, WB_ALU, 0), E(1, 0, 0, WB_ALU, 0, 0, 0, 0, 1));
    // ALU writes, including x0.
    add(S(1, 1, 5, 1, WB_ALU, 0), E(1, 1, 5, WB_ALU, 1, 0, 0, 0, 1));
    add(S(1, 1, 0, 1, WB_ALU, 0), E(1, 0, 0, WB_ALU, 1, 0, 0, 0, 1));
    // Zero-wait load followed back-to-back by a CSR write.
    add(S(1, 1, 7, 1, WB_MEM, 1), E(1, 1, 7, WB_MEM, 1, 0, 0, 0, 1));
    add(S(1, 1, 3, 1, WB_CSR, 0), E(1, 1, 3, WB_CSR, 1, 0, 0, 0, 1));
    // Waited load: rvalid four cycles after acceptance; requests during the wait are ignored.
    add(S(1, 1, 9, 1, WB_MEM, 0), E(1, 0, 0, WB_MEM, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) add(S(1, 1, 4, 1, WB_PC, 0), E(0, 0, 9, WB_MEM, 0, 1, 9, 0, 1));
    add(S(1, 1, 4, 1, WB_PC, 1), E(0, 1, 9, WB_MEM, 1, 1, 9, 0, 1));
    // Spurious rvalid in IDLE, then a PC write with we low.
    add(S(1, 0, 0, 0, WB_ALU, 1), E(1, 0, 0, WB_ALU, 0, 0, 0, 0, 1));
    add(S(1, 1, 12, 0, WB_PC, 0), E(1, 0, 12, WB_PC, 1, 0, 0, 0, 1));
    // Reset while a load waits drops it; late rvalid writes nothing.
    add(S(1, 1, 10, 1, WB_MEM, 0), E(1, 0, 0, WB_MEM, 0, 0, 0, 0, 0));
    add(S(1, 0, 0, 0, WB_ALU, 0), E(0, 0, 10, WB_MEM, 0, 1, 10, 0, 1));
    add(S(0, 0, 0, 0, WB_ALU, 0), E(0, 0, 0, WB_ALU, 0, 0, 0, 0, 1));
    add(S(1, 0, 0, 0, WB_ALU, 1), E(1, 0, 0, WB_ALU, 0, 0, 0, 0, 1));
    // Waited load to x0 retires without a strobe.
    add(S(1, 1, 0, 1, WB_MEM, 0), E(1, 0, 0, WB_MEM, 0, 0, 0, 0, 0));
    add(S(1, 0, 0, 0, WB_ALU, 1), E(0, 0, 0, WB_MEM, 1, 1, 0, 0, 1));
`ifdef RISCV_WB_TIMEOUT_EN
    // No rvalid: abort on the wait cycle where the limit is reached.
    add(S(1, 1, 11, 1, WB_MEM, 0), E(1, 0, 0, WB_MEM, 0, 0, 0, 0, 0));
    for (int i = 0; i < MEM_TO; i++) add(S(1, 0, 0, 0, WB_ALU, 0), E(0, 0, 11, WB_MEM, 0, 1, 11, 0, 1));
    add(S(1, 0, 0, 0, WB_ALU, 0), E(0, 0, 11, WB_MEM, 0, 1, 11, 1, 1));
    add(S(1, 0, 0, 0, WB_ALU, 1), E(1, 0, 0, WB_ALU, 0, 0, 0, 0, 1));
    // rvalid exactly at the limit completes normally.
    add(S(1, 1, 13, 1, WB_MEM, 0), E(1, 0, 0, WB_MEM, 0, 0, 0, 0, 0));
    for (int i = 0; i < MEM_TO; i++) add(S(1, 0, 0, 0, WB_ALU, 0), E(0, 0, 13, WB_MEM, 0, 1, 13, 0, 1));
    add(S(1, 0, 0, 0, WB_ALU, 1), E(0, 1, 13, WB_MEM, 1, 1, 13, 0, 1));
    add(S(1, 0, 0, 0, WB_ALU, 0), E(1, 0, 0, WB_ALU, 0, 0, 0, 0, 1));
`else
    // Without the abort feature a long wait never errors.
    add(S(1, 1, 14, 1, WB_MEM, 0), E(1, 0, 0, WB_MEM, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) add(S(1, 0, 0, 0, WB_ALU, 0), E(0, 0, 14, WB_MEM, 0, 1, 14, 0, 1));
    add(S(1, 0, 0, 0, WB_ALU, 1), E(0, 1, 14, WB_MEM, 1, 1, 14, 0, 1));
`endif

    @(posedge clk);
    #1;
    foreach (tbl[i]) step(tbl[i].s, tbl[i].e, i);

    // Randomized traffic checked against the reference model, starting from reset.
    for (int i = 0; i < 600; i++) begin
      stim_t s;
      exp_t  e;
      s.rst_n = (i < 2) ? 1'b0 : ($urandom_range(0, 99) >= 2);
      s.v     = ($urandom_range(0, 99) < 70);
      s.rd    = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) s.rd = 5'd0;
      s.we    = ($urandom_range(0, 3) != 0);
      s.sel   = ($urandom_range(0, 1) == 1) ? WB_MEM : wb_sel_e'($urandom_range(0, 3));
      s.rv    = ($urandom_range(0, 99) < 25);
      e = model(s);
      step(s, e, 1000 + i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
